// File: rtl/cmd_packet_parser_if.sv
// Bundles the UART byte stream, the downstream command handshake and the
// status pulses of the command packet parser.
interface cmd_packet_parser_if #(
  parameter int DATA_BIT = 8
);
  logic                i_rx_done_tick;
  logic [DATA_BIT-1:0] i_data;
  logic                i_cmd_ready;
  logic                o_cmd_valid;
  logic [DATA_BIT-1:0] o_out_pattern;
  logic [DATA_BIT-1:0] o_freq_pattern;
  logic [3:0]          o_channel;
  logic                o_mode;
  logic                o_stop;
  logic                o_start;
  logic                o_frame_err;
  logic                o_overrun;

  // Parser side: consumes bytes and ready, produces the held command.
  modport slave (
    input  i_rx_done_tick, i_data, i_cmd_ready,
    output o_cmd_valid, o_out_pattern, o_freq_pattern, o_channel,
           o_mode, o_stop, o_start, o_frame_err, o_overrun
  );

  // Environment side: UART receiver plus downstream serializer.
  modport master (
    output i_rx_done_tick, i_data, i_cmd_ready,
    input  o_cmd_valid, o_out_pattern, o_freq_pattern, o_channel,
           o_mode, o_stop, o_start, o_frame_err, o_overrun
  );
endinterface

// File: rtl/cmd_packet_parser.sv
// Assembles 3-byte UART command packets (output pattern, frequency pattern,
// control byte) into a single held command with a valid/ready handshake.
// Inter-byte gaps longer than TIMEOUT_CLK clocks or a set reserved control
// bit discard the packet and pulse o_frame_err; a valid packet arriving
// while the held command cannot be released is dropped with o_overrun.
module cmd_packet_parser #(
  parameter int DATA_BIT    = 8,
  parameter int TIMEOUT_CLK = 20000
) (
  input logic                  clk,
  input logic                  rst_n,
  cmd_packet_parser_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLK - 1);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_BIT-1:0] stage_b0;
  logic [DATA_BIT-1:0] stage_b1;

  // Handshake terms shared by the FSM below.
  logic strobe;
  logic release_ok;
  logic timed_out;

  assign strobe     = bus.i_rx_done_tick;
  assign release_ok = !bus.o_cmd_valid || bus.i_cmd_ready;
  assign timed_out  = !strobe && (cnt == CNT_LAST);

  // Packet FSM, inter-byte timeout counter and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= WAIT_B0;
      cnt                <= '0;
      stage_b0           <= '0;
      stage_b1           <= '0;
      bus.o_cmd_valid    <= 1'b0;
      bus.o_out_pattern  <= '0;
      bus.o_freq_pattern <= '0;
      bus.o_channel      <= '0;
      bus.o_mode         <= 1'b0;
      bus.o_stop         <= 1'b0;
      bus.o_start        <= 1'b0;
      bus.o_frame_err    <= 1'b0;
      bus.o_overrun      <= 1'b0;
    end else begin
      // NOTE: status pulses default low every cycle and are raised only by
      // the branch that detects the event, so each lasts exactly one clock;
      // all state here uses <= so every branch sees pre-edge values.
      bus.o_frame_err <= 1'b0;
      bus.o_overrun   <= 1'b0;

      // A transfer retires the held command; a load below may refill it.
      if (bus.o_cmd_valid && bus.i_cmd_ready) begin
        bus.o_cmd_valid <= 1'b0;
      end

      case (state)
        WAIT_B0: begin
          cnt <= '0;
          if (strobe) begin
            stage_b0 <= bus.i_data;
            state    <= WAIT_B1;
          end
        end

        WAIT_B1: begin
          if (strobe) begin
            stage_b1 <= bus.i_data;
            cnt      <= '0;
            state    <= WAIT_B2;
          end else if (timed_out) begin
            stage_b0        <= '0;
            cnt             <= '0;
            bus.o_frame_err <= 1'b1;
            state           <= WAIT_B0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_B2: begin
          if (strobe) begin
            cnt      <= '0;
            stage_b0 <= '0;
            stage_b1 <= '0;
            state    <= WAIT_B0;
            if (bus.i_data[7]) begin
              bus.o_frame_err <= 1'b1;
            end else if (release_ok) begin
              bus.o_cmd_valid    <= 1'b1;
              bus.o_out_pattern  <= stage_b0;
              bus.o_freq_pattern <= stage_b1;
              bus.o_channel      <= bus.i_data[6:3];
              bus.o_mode         <= bus.i_data[2];
              bus.o_stop         <= bus.i_data[1];
              bus.o_start        <= bus.i_data[0];
            end else begin
              bus.o_overrun <= 1'b1;
            end
          end else if (timed_out) begin
            stage_b0        <= '0;
            stage_b1        <= '0;
            cnt             <= '0;
            bus.o_frame_err <= 1'b1;
            state           <= WAIT_B0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          cnt   <= '0;
          state <= WAIT_B0;
        end
      endcase
    end
  end

endmodule
